// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-store load controller.
//   state_t       controller states (FILL, RUN, LOAD)
//   DEF_DEPTH     default number of 32-bit instruction words
//   DEF_ADDR_W    default word-address width (log2 of DEF_DEPTH)
//   INSTR_ZERO    value fetched for stalled or out-of-range reads
package imem_pkg;
  localparam int DEF_DEPTH  = 128;
  localparam int DEF_ADDR_W = 7;
  localparam logic [31:0] INSTR_ZERO = 32'h0;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;
endpackage

// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if: fetch and loader signals of the instruction store.
//   master: core/loader side (drives PC and the load request/data stream)
//   slave : controller side (drives Instr, Stall, LoadReady, LoadDone)
// With LOAD_CHECKSUM_EN defined, LoadSum (running sum of accepted words)
// is added to the bundle.
interface imem_load_ctrl_if #(parameter int ADDR_W = 7);
  logic [31:0]     PC;
  logic [31:0]     Instr;
  logic            Stall;
  logic            LoadStart;
  logic [ADDR_W:0] LoadLen;
  logic            LoadValid;
  logic [31:0]     LoadData;
  logic            LoadReady;
  logic            LoadDone;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0]     LoadSum;

  modport master (output PC, LoadStart, LoadLen, LoadValid, LoadData,
                  input  Instr, Stall, LoadReady, LoadDone, LoadSum);
  modport slave  (input  PC, LoadStart, LoadLen, LoadValid, LoadData,
                  output Instr, Stall, LoadReady, LoadDone, LoadSum);
`else
  modport master (output PC, LoadStart, LoadLen, LoadValid, LoadData,
                  input  Instr, Stall, LoadReady, LoadDone);
  modport slave  (input  PC, LoadStart, LoadLen, LoadValid, LoadData,
                  output Instr, Stall, LoadReady, LoadDone);
`endif
endinterface

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x 32 instruction storage.
//   clk          write clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous (combinational) read port
// Contents are not reset; the controller clears them by filling.
module imem_ram #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the instruction store and sequences fetch vs. load.
//   CLK, RESETn  clock, asynchronous active-low reset
//   bus (slave)  PC/Instr/Stall fetch path; LoadStart/LoadLen request,
//                LoadValid/LoadData/LoadReady word stream, LoadDone pulse
// After reset the store is zero-filled (Stall high for DEPTH cycles).
// A load writes LoadLen words from address 0, then zero-fills the tail and
// pulses LoadDone in the first RUN cycle.
// Optional: define LOAD_CHECKSUM_EN to add LoadSum, the modulo-2^32 sum of
// the words accepted since the last accepted LoadStart.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic              CLK,
  input logic              RESETn,
  imem_load_ctrl_if.slave  bus
);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] MAX_LEN  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] ptr_q, cnt_q;
  logic            from_load_q;   // current FILL is the tail of a load
  logic            done_q;
  logic            we, start_ok, accept, fill_end, last_acc;
  logic [31:0]     wdata, rdata;

  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) state_q <= ST_FILL;
    else         state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    wdata    = INSTR_ZERO;
    start_ok = 1'b0;
    accept   = 1'b0;
    fill_end = 1'b0;
    last_acc = 1'b0;
    case (state_q)
      ST_FILL: begin
        we       = 1'b1;
        fill_end = (ptr_q == LAST_IDX);
        if (fill_end) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.LoadStart && bus.LoadLen != '0 && bus.LoadLen <= MAX_LEN) begin
          start_ok = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.LoadValid) begin
          accept   = 1'b1;
          we       = 1'b1;
          wdata    = bus.LoadData;
          last_acc = (cnt_q == ONE);
          // A full-length load needs no tail fill.
          if (last_acc) state_d = (ptr_q == LAST_IDX) ? ST_RUN : ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      from_load_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (fill_end && from_load_q) || (last_acc && ptr_q == LAST_IDX);
      if (start_ok) begin
        ptr_q <= '0;
        cnt_q <= bus.LoadLen;
      end else if (accept) begin
        ptr_q <= ptr_q + ONE;
        cnt_q <= cnt_q - ONE;
        if (last_acc && ptr_q != LAST_IDX) from_load_q <= 1'b1;
      end else if (state_q == ST_FILL) begin
        ptr_q <= ptr_q + ONE;
        if (fill_end) from_load_q <= 1'b0;
      end
    end

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn)       sum_q <= '0;
    else if (start_ok) sum_q <= '0;
    else if (accept)   sum_q <= sum_q + bus.LoadData;
  assign bus.LoadSum = sum_q;
`endif

  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (ptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (bus.PC[ADDR_W+1:2]),
    .rdata (rdata)
  );

  // Reads are blanked while stalled and for PCs beyond the store.
  assign bus.Stall     = (state_q != ST_RUN);
  assign bus.LoadReady = (state_q == ST_LOAD);
  assign bus.LoadDone  = done_q;
  assign bus.Instr     = (bus.Stall || (|bus.PC[31:ADDR_W+2])) ? INSTR_ZERO : rdata;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed sequence with randomized data/handshake for
// imem_load_ctrl. The expected store image is kept as a plain array updated
// from the load rules (first LoadLen words = data, rest = 0); timing
// expectations are plain arithmetic (DEPTH boot cycles, DEPTH-len fill).
module tb_imem_load_ctrl;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic CLK = 1'b0;
  logic RESETn;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] ldata [DEPTH];

  imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts Stall-high cycles after reset release; store must read as zero.
  task automatic boot_check();
    int n = 0;
    while (bus.Stall && n < 300) begin
      bus.PC = $urandom;
      #1;
      chk("boot_instr", bus.Instr, 32'h0);
      chk("boot_ready", bus.LoadReady, 32'h0);
      chk("boot_nodone", bus.LoadDone, 32'h0);
      step();
      n++;
    end
    chk("boot_cycles", n, DEPTH);
    chk("boot_nodone_run", bus.LoadDone, 32'h0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
`ifdef LOAD_CHECKSUM_EN
    chk("sum_reset", bus.LoadSum, 32'h0);
`endif
  endtask

  task automatic read_all();
    logic [31:0] pc;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      pc = (32'(i) << 2) | 32'($urandom_range(0, 3));
      bus.PC = pc;
      #1;
      chk("rd_word", bus.Instr, model[i]);
      chk("rd_stall", bus.Stall, 32'h0);
    end
    // Out-of-range PCs alias a word in the low bits but must read 0.
    for (int k = 0; k < 4; k++) begin
      step();
      pc = (32'($urandom_range(1, 255)) << (ADDR_W + 2)) | 32'($urandom_range(0, 511));
      bus.PC = pc;
      #1;
      chk("rd_oob", bus.Instr, 32'h0);
    end
  endtask

  // mode 0: LoadValid held high; 1: random; 2: toggles every other cycle.
  task automatic do_load(input int len, input int mode, input bit poke_start);
    int idx = 0, cyc = 0, n = 0;
    logic v;
    logic [31:0] sum = 32'h0;
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 8'(len);
    step();
    bus.LoadStart = 1'b0;
    chk("load_stall", bus.Stall, 32'h1);
    while (idx < len && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (cyc % 2 == 0);
      endcase
      bus.LoadValid = v;
      bus.LoadData  = ldata[idx];
      if (poke_start && cyc == 0) begin
        bus.LoadStart = 1'b1;
        bus.LoadLen   = 8'd5;
      end
      #1;
      chk("load_ready", bus.LoadReady, 32'h1);
      chk("load_instr", bus.Instr, 32'h0);
      step();
      bus.LoadStart = 1'b0;
      if (v) begin
        sum = sum + ldata[idx];
        idx++;
      end
      cyc++;
    end
    bus.LoadValid = 1'b0;
    chk("load_accepts", idx, len);
    for (int i = 0; i < DEPTH; i++) model[i] = (i < len) ? ldata[i] : 32'h0;
    while (bus.Stall && n < 300) begin
      chk("fill_ready", bus.LoadReady, 32'h0);
      chk("fill_nodone", bus.LoadDone, 32'h0);
      step();
      n++;
    end
    chk("fill_cycles", n, DEPTH - len);
    chk("done_pulse", bus.LoadDone, 32'h1);
`ifdef LOAD_CHECKSUM_EN
    chk("load_sum", bus.LoadSum, sum);
`endif
    step();
    chk("done_clear", bus.LoadDone, 32'h0);
  endtask

  task automatic try_invalid(input logic [7:0] len);
    bus.LoadStart = 1'b1;
    bus.LoadLen   = len;
    step();
    bus.LoadStart = 1'b0;
    chk("inv_stall", bus.Stall, 32'h0);
    chk("inv_ready", bus.LoadReady, 32'h0);
    step();
    chk("inv_stall2", bus.Stall, 32'h0);
    chk("inv_nodone", bus.LoadDone, 32'h0);
  endtask

  initial begin
    int len;
    RESETn        = 1'b0;
    bus.PC        = 32'h0;
    bus.LoadStart = 1'b0;
    bus.LoadLen   = '0;
    bus.LoadValid = 1'b0;
    bus.LoadData  = 32'h0;
    repeat (3) step();
    #1;
    chk("rst_stall", bus.Stall, 32'h1);
    chk("rst_ready", bus.LoadReady, 32'h0);
    chk("rst_done", bus.LoadDone, 32'h0);
    step();
    RESETn = 1'b1;
    boot_check();
    read_all();

    // Three-word program, with a LoadStart poked mid-load that must be ignored.
    ldata[0] = 32'hE59F1204;
    ldata[1] = 32'hE59F2204;
    ldata[2] = 32'hEAFFFFFE;
    do_load(3, 0, 1'b1);
    step();
    bus.PC = 32'd12;
    #1;
    chk("pc12_zero", bus.Instr, 32'h0);
    read_all();

    // Full image with toggling valid: no tail fill.
    for (int i = 0; i < DEPTH; i++) ldata[i] = $urandom;
    do_load(DEPTH, 2, 1'b0);
    step();
    bus.PC = 32'h1FC;
    #1;
    chk("pc_last", bus.Instr, ldata[DEPTH-1]);
    read_all();

    // Short reload over a full image clears the tail.
    for (int i = 0; i < DEPTH; i++) ldata[i] = $urandom;
    do_load(2, 1, 1'b0);
    read_all();

    try_invalid(8'd0);
    try_invalid(8'd129);
    try_invalid(8'($urandom_range(130, 255)));

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) ldata[i] = $urandom;
      len = $urandom_range(1, DEPTH);
      do_load(len, 1, 1'($urandom_range(0, 1)));
      read_all();
    end

`ifdef LOAD_CHECKSUM_EN
    ldata[0] = 32'hFFFFFFFF;
    ldata[1] = 32'h00000002;
    do_load(2, 0, 1'b0);
    chk("sum_wrap", bus.LoadSum, 32'h1);
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 8'd1;
    step();
    bus.LoadStart = 1'b0;
    chk("sum_clear", bus.LoadSum, 32'h0);
    bus.LoadValid = 1'b1;
    bus.LoadData  = 32'h12345678;
    step();
    bus.LoadValid = 1'b0;
    begin
      int n = 0;
      while (bus.Stall && n < 300) begin step(); n++; end
      chk("sum_fill", n, DEPTH - 1);
    end
    chk("sum_hold", bus.LoadSum, 32'h12345678);
`endif

    // Reset after 5 of 10 words accepted.
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 8'd10;
    step();
    bus.LoadStart = 1'b0;
    bus.LoadValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.LoadData = $urandom | 32'h1;
      step();
    end
    #2;
    RESETn = 1'b0;
    bus.LoadValid = 1'b0;
    #1;
    chk("abort_stall", bus.Stall, 32'h1);
    chk("abort_ready", bus.LoadReady, 32'h0);
    chk("abort_done", bus.LoadDone, 32'h0);
    chk("abort_instr", bus.Instr, 32'h0);
    step();
    RESETn = 1'b1;
    boot_check();
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Owns the processor's 128-word instruction store and sequences access to it. Normally it serves combinational instruction fetch to the core. On request, it stalls the core, accepts a new program word by word from a loader (UART or debug bridge) over a valid/ready handshake, then zero-fills the unused tail. This replaces the fixed boot image with a runtime-loadable one, with the same "unused words read as 0" guarantee.

Parameters:
DEPTH, 128, number of 32-bit instruction words.
ADDR_W, 7, word-address width; must equal log2(DEPTH).

Ports:
CLK  in  1  system clock, all state updates on rising edge.
RESETn  in  1  asynchronous active-low reset.
PC  in  32  byte address from fetch stage; word index is PC[ADDR_W+1:2].
Instr  out  32  fetched instruction.
Stall  out  1  core must hold PC and not commit while high.
LoadStart  in  1  request a program load; sampled only in RUN.
LoadLen  in  ADDR_W+1  number of words to load, 1..DEPTH; sampled with LoadStart.
LoadValid  in  1  LoadData holds a valid word.
LoadData  in  32  program word.
LoadReady  out  1  controller accepts LoadData this cycle.
LoadDone  out  1  one-cycle pulse when a load and its tail fill are complete.

Behaviour:
- States: FILL, RUN, LOAD. Internal registers: ptr (ADDR_W+1 bits) and remaining word count cnt (ADDR_W+1 bits).
- Reset (RESETn low, asynchronous): state=FILL, ptr=0, cnt=0, Stall=1, LoadReady=0, LoadDone=0. Memory contents are not reset; FILL clears them.
- FILL:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - When ptr==DEPTH-1 has been written, next state is RUN.
  - Cold boot takes exactly DEPTH cycles after reset release before Stall falls.
- RUN:
  - Stall=0, Instr = mem[PC[ADDR_W+1:2]] combinationally (zero latency).
  - If PC[31:ADDR_W+2] is nonzero, Instr=0.
  - PC[1:0] is ignored.
  - LoadStart=1 with LoadLen in 1..DEPTH: latch cnt=LoadLen, set ptr=0, go to LOAD. Stall rises the next cycle.
  - LoadStart with LoadLen=0 or LoadLen>DEPTH is ignored; state stays RUN.
- LOAD:
  - Stall=1, LoadReady=1.
  - Each cycle with LoadValid&LoadReady: mem[ptr]=LoadData, ptr++, cnt--.
  - When the accepted word makes cnt reach 0:
    - if ptr becomes DEPTH, go to RUN and pulse LoadDone in the first RUN cycle;
    - otherwise go to FILL starting at the current ptr.
  - LoadValid low: nothing changes (no timeout).
- FILL entered after a load: on completion go to RUN with a LoadDone pulse. LoadDone is not pulsed after reset-initiated FILL.
- Instr = 0 whenever Stall=1.
- LoadStart outside RUN is ignored. LoadReady is 0 outside LOAD.
- Reset mid-LOAD or mid-FILL aborts: partially loaded words are overwritten by the reset FILL, and no LoadDone is issued.
- No simultaneous read/write hazard: writes occur only while Stall=1.

Optional Feature:
LOAD_CHECKSUM_EN:
- When defined, adds output LoadSum (32 bits).
  - Reset to 0.
  - Cleared when LoadStart is accepted.
  - Adds each accepted LoadData modulo 2^32.
  - Holds its value after load completion until the next accepted LoadStart.
- When not defined, the port and adder are absent and behaviour is otherwise identical.

Decomposition:
- Package imem_pkg holds:
  - state encoding (FILL, RUN, LOAD);
  - default DEPTH/ADDR_W constants;
  - the INSTR_ZERO constant (32'h0).
- Sub-module imem_ram holds the DEPTH x 32 storage: one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The controller FSM, counters and output muxing live in imem_load_ctrl.

Test Plan:
- Reset release:
  - Stall=1 for exactly 128 cycles, then 0.
  - Any PC reads Instr=0.
  - LoadDone never pulses.
- Load 3 words (E59F1204, E59F2204, EAFFFFFE), LoadValid held high:
  - LoadReady high for 3 cycles, then FILL of 125 cycles, then a single LoadDone pulse.
  - PC=0/4/8 read the three words; PC=12 reads 0.
- Load 128 words with LoadValid toggling every other cycle:
  - exactly 128 accepts, direct LOAD->RUN with no FILL;
  - PC=0x1FC returns the last word.
- Reloads and invalid requests:
  - Reload 2 words over a full image: words 2..127 read 0 afterward.
  - LoadLen=0 or 129: stays RUN, Stall stays 0.
  - LoadStart during LOAD: ignored.
- RESETn low after 5 of 10 words are accepted:
  - immediate Stall=1, LoadReady=0;
  - after 128 cycles all words read 0;
  - no LoadDone.
- With LOAD_CHECKSUM_EN, load FFFFFFFF and 00000002:
  - LoadSum=00000001;
  - a new LoadStart clears it to 0.
